imem_refill_resp: RTL and testbench

- Memory-side responder for instruction-cache line refills.
- Accepts one 16-byte line request at a time and returns the line as BEATS consecutive 32-bit words over a valid/ready burst channel.
- Data comes from an internal word array after a programmable access latency.
- A side write port lets the testbench or loader preload program images. Used as the instruction memory model under the icache in place of direct DPI reads.

---
 rtl/imem_refill_resp_if.sv | 31 +++
 rtl/imem_refill_resp.sv | 128 ++++++++++++
 tb/tb_imem_refill_resp.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_refill_resp_if.sv
// Refill channel between an instruction-cache requester and the memory-side
// responder: line request, beat response burst and the preload write port.
interface imem_refill_resp_if #(
   parameter int XLEN = 32
);
   logic            req_valid_i;
   logic            req_ready_o;
   logic [XLEN-1:0] req_addr_i;
   logic            resp_valid_o;
   logic            resp_ready_i;
   logic [XLEN-1:0] resp_data_o;
   logic            resp_last_o;
   logic            resp_err_o;
   logic            init_we_i;
   logic [XLEN-1:0] init_addr_i;
   logic [XLEN-1:0] init_data_i;

   // Requester / loader side.
   modport master (
      output req_valid_i, req_addr_i, resp_ready_i,
      output init_we_i, init_addr_i, init_data_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_last_o, resp_err_o
   );

   // Memory responder side.
   modport slave (
      input  req_valid_i, req_addr_i, resp_ready_i,
      input  init_we_i, init_addr_i, init_data_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_last_o, resp_err_o
   );
endinterface

// File: rtl/imem_refill_resp.sv
// Instruction memory responder for cache line refills. Accepts one line
// request at a time, waits LATENCY cycles, then streams BEATS words in
// ascending address order. Lines that run past the array are answered with
// the error flag set and zero data. A preload port writes the array at any time.
module imem_refill_resp #(
   parameter int XLEN      = 32,
   parameter int MEM_WORDS = 4096,
   parameter int LATENCY   = 3,
   parameter int BEATS     = 4
) (
   input  logic              clk_i,
   input  logic              rst,
   imem_refill_resp_if.slave bus
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t          state_reg, state_next;
   logic [BW-1:0]   beat_reg, beat_next;
   logic [3:0]      lat_reg, lat_next;
   logic [AW-1:0]   line_word_reg, line_word_next;
   logic            err_reg, err_next;

   logic [XLEN-1:0] mem [MEM_WORDS];

   logic [XLEN-3:0] req_word;
   logic [XLEN:0]   req_end_word;
   logic            req_err;
   logic [AW-1:0]   rd_word;
   logic            last_beat;
   logic            req_ready;
   logic            resp_valid;
   logic            unused_addr_bits;

   // Word index of the line base: low word bits inside the line are dropped.
   assign req_word     = bus.req_addr_i[XLEN-1:2] & ~((XLEN-2)'(BEATS - 1));
   // One bit wider than the address so a line near the top of the address
   // space cannot wrap around and look in range.
   assign req_end_word = {3'b000, req_word} + (XLEN+1)'(BEATS);
   assign req_err      = req_end_word > (XLEN+1)'(MEM_WORDS);

   assign rd_word   = line_word_reg + AW'(beat_reg);
   assign last_beat = (beat_reg == BW'(BEATS - 1));

   // Byte-offset bits and out-of-array preload address bits carry no meaning.
   assign unused_addr_bits = ^{bus.req_addr_i[1:0], bus.init_addr_i[1:0],
                               bus.init_addr_i[XLEN-1:AW+2]};

   // State, beat/latency counters and the latched line.
   always_ff @(posedge clk_i) begin
      if (!rst) begin
         state_reg     <= IDLE;
         beat_reg      <= '0;
         lat_reg       <= '0;
         line_word_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         beat_reg      <= beat_next;
         lat_reg       <= lat_next;
         line_word_reg <= line_word_next;
         err_reg       <= err_next;
      end
   end

   // Next-state and handshake logic; outputs are forced idle while reset is low.
   always_comb begin
      state_next     = state_reg;
      beat_next      = beat_reg;
      lat_next       = lat_reg;
      line_word_next = line_word_reg;
      err_next       = err_reg;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = rst;
            if (bus.req_valid_i && req_ready) begin
               line_word_next = req_word[AW-1:0];
               err_next       = req_err;
               beat_next      = '0;
               if (LATENCY == 0) begin
                  state_next = BURST;
               end else begin
                  state_next = WAIT;
                  lat_next   = 4'(LATENCY);
               end
            end
         end
         WAIT: begin
            lat_next = lat_reg - 4'd1;
            if (lat_reg <= 4'd1) begin
               state_next = BURST;
            end
         end
         BURST: begin
            resp_valid = rst;
            if (resp_valid && bus.resp_ready_i) begin
               if (last_beat) begin
                  state_next = IDLE;
                  beat_next  = '0;
               end else begin
                  beat_next = beat_reg + BW'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Preload port; the array is never cleared by reset.
   always_ff @(posedge clk_i) begin
      if (bus.init_we_i) begin
         mem[bus.init_addr_i[AW+1:2]] <= bus.init_data_i;
      end
   end

   assign bus.req_ready_o  = req_ready;
   assign bus.resp_valid_o = resp_valid;
   assign bus.resp_last_o  = resp_valid && last_beat;
   assign bus.resp_err_o   = resp_valid && err_reg;
   // Combinational read so a preload to the presented word shows up next cycle.
   assign bus.resp_data_o  = err_reg ? '0 : mem[rd_word];
endmodule

// File: tb/tb_imem_refill_resp.sv
// Bench for imem_refill_resp: one LATENCY=3 instance (d=0) and one LATENCY=0
// instance (d=1), directed scenarios followed by randomized bursts, checked
// every cycle against a timestamp-based model of the refill protocol.
module tb_imem_refill_resp;
   localparam int MEM_WORDS = 4096;
   localparam int BEATS     = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [31:0] req_addr [2];
   logic [1:0]  resp_ready;
   logic        init_we;
   logic [31:0] init_addr;
   logic [31:0] init_data;

   logic [1:0]  obs_ready, obs_valid, obs_last, obs_err;
   logic [31:0] obs_data [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   imem_refill_resp_if #(.XLEN(32)) if0 ();
   imem_refill_resp_if #(.XLEN(32)) if1 ();

   imem_refill_resp #(.XLEN(32), .MEM_WORDS(MEM_WORDS), .LATENCY(3), .BEATS(BEATS)) u_lat3 (
      .clk_i (clk),
      .rst   (rst),
      .bus   (if0)
   );

   imem_refill_resp #(.XLEN(32), .MEM_WORDS(MEM_WORDS), .LATENCY(0), .BEATS(BEATS)) u_lat0 (
      .clk_i (clk),
      .rst   (rst),
      .bus   (if1)
   );

   assign if0.req_valid_i  = req_valid[0];
   assign if0.req_addr_i   = req_addr[0];
   assign if0.resp_ready_i = resp_ready[0];
   assign if0.init_we_i    = init_we;
   assign if0.init_addr_i  = init_addr;
   assign if0.init_data_i  = init_data;
   assign if1.req_valid_i  = req_valid[1];
   assign if1.req_addr_i   = req_addr[1];
   assign if1.resp_ready_i = resp_ready[1];
   assign if1.init_we_i    = init_we;
   assign if1.init_addr_i  = init_addr;
   assign if1.init_data_i  = init_data;

   assign obs_ready[0] = if0.req_ready_o;
   assign obs_valid[0] = if0.resp_valid_o;
   assign obs_last[0]  = if0.resp_last_o;
   assign obs_err[0]   = if0.resp_err_o;
   assign obs_data[0]  = if0.resp_data_o;
   assign obs_ready[1] = if1.req_ready_o;
   assign obs_valid[1] = if1.resp_valid_o;
   assign obs_last[1]  = if1.resp_last_o;
   assign obs_err[1]   = if1.resp_err_o;
   assign obs_data[1]  = if1.resp_data_o;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 3 : 0;
   endfunction

   // Reference model: memory image plus, per instance, the outstanding line
   // and the cycle its first beat is due.
   logic [31:0] shadow [MEM_WORDS];
   bit          shadow_vld [MEM_WORDS];
   bit          m_busy  [2];
   int          m_first [2];
   int          m_beat  [2];
   logic [31:0] m_line  [2];
   bit          m_err   [2];

   typedef struct {
      int          d;
      int          cyc;
      logic [31:0] data;
      logic        last;
      logic        err;
   } beat_t;
   beat_t beat_log [$];
   int    dut_acc_cnt [2];
   int    acc_cyc [2];

   // Per-cycle monitor: compare outputs with the model, then advance it.
   initial begin
      bit          mon_exp_valid;
      int          mon_widx;
      logic [31:0] mon_exp_data;
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 1'b0; m_first[d] = 0; m_beat[d] = 0; m_line[d] = '0; m_err[d] = 1'b0;
         dut_acc_cnt[d] = 0; acc_cyc[d] = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            if (!rst) begin
               check_eq($sformatf("rst_ready_d%0d", d), 32'(obs_ready[d]), 32'd0);
               check_eq($sformatf("rst_valid_d%0d", d), 32'(obs_valid[d]), 32'd0);
               check_eq($sformatf("rst_last_d%0d", d),  32'(obs_last[d]),  32'd0);
               check_eq($sformatf("rst_err_d%0d", d),   32'(obs_err[d]),   32'd0);
               m_busy[d] = 1'b0;
            end else begin
               mon_exp_valid = m_busy[d] && (cyc >= m_first[d]);
               check_eq($sformatf("ready_d%0d_c%0d", d, cyc), 32'(obs_ready[d]), 32'(!m_busy[d]));
               check_eq($sformatf("valid_d%0d_c%0d", d, cyc), 32'(obs_valid[d]), 32'(mon_exp_valid));
               if (obs_ready[d] && req_valid[d]) begin
                  dut_acc_cnt[d]++;
                  acc_cyc[d] = cyc;
               end
               if (obs_valid[d] && resp_ready[d]) begin
                  beat_log.push_back('{d, cyc, obs_data[d], obs_last[d], obs_err[d]});
               end
               if (mon_exp_valid) begin
                  mon_widx     = int'(((m_line[d] >> 2) + 32'(m_beat[d])) % 32'(MEM_WORDS));
                  mon_exp_data = m_err[d] ? 32'd0 : shadow[mon_widx];
                  if (m_err[d] || shadow_vld[mon_widx]) begin
                     check_eq($sformatf("data_d%0d_c%0d", d, cyc), obs_data[d], mon_exp_data);
                  end
                  check_eq($sformatf("last_d%0d_c%0d", d, cyc), 32'(obs_last[d]), 32'(m_beat[d] == BEATS - 1));
                  check_eq($sformatf("err_d%0d_c%0d", d, cyc),  32'(obs_err[d]),  32'(m_err[d]));
                  if (resp_ready[d]) begin
                     m_beat[d]++;
                     if (m_beat[d] == BEATS) m_busy[d] = 1'b0;
                  end
               end else if (!m_busy[d] && req_valid[d]) begin
                  m_busy[d]  = 1'b1;
                  m_line[d]  = req_addr[d] & ~32'(BEATS * 4 - 1);
                  m_err[d]   = ((longint'(m_line[d]) >> 2) + BEATS) > MEM_WORDS;
                  m_beat[d]  = 0;
                  m_first[d] = cyc + lat_of(d) + 1;
               end
            end
         end
         if (init_we) begin
            shadow[(init_addr >> 2) % MEM_WORDS]     = init_data;
            shadow_vld[(init_addr >> 2) % MEM_WORDS] = 1'b1;
         end
      end
   end

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      init_we = 1'b1; init_addr = addr; init_data = data;
      @(posedge clk); #1;
      init_we = 1'b0;
   endtask

   task automatic wait_accept(input int d);
      int start;
      int n;
      start = dut_acc_cnt[d];
      n = 0;
      while (dut_acc_cnt[d] == start && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq($sformatf("accept_d%0d", d), 32'(dut_acc_cnt[d] != start), 32'd1);
   endtask

   task automatic run_beats(input int d, input int start, input int pct,
                            input int stall_beat, input int stall_len, input bit rand_wr);
      int n;
      int stalled;
      int idx;
      n = 0; stalled = 0;
      while (beat_log.size() < start + BEATS && n < 400) begin
         idx = beat_log.size() - start;
         if (idx == stall_beat && stalled < stall_len) begin
            resp_ready[d] = 1'b0;
            stalled++;
         end else begin
            resp_ready[d] = ($urandom_range(1, 100) <= pct);
         end
         if (rand_wr && $urandom_range(0, 3) == 0) begin
            init_we   = 1'b1;
            init_addr = (req_addr[d] & ~32'hF) + 32'($urandom_range(0, 3) * 4);
            init_data = $urandom;
         end else begin
            init_we = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      init_we = 1'b0;
      resp_ready[d] = 1'b0;
      check_eq($sformatf("burst_done_d%0d", d), 32'(beat_log.size() >= start + BEATS), 32'd1);
      $display("burst dut%0d addr %h beats %0d cycles %0d", d, req_addr[d], beat_log.size() - start, n);
   endtask

   task automatic request(input int d, input logic [31:0] addr, input int pct,
                          input int stall_beat, input int stall_len, input bit rand_wr);
      int s;
      s = beat_log.size();
      req_valid[d] = 1'b1;
      req_addr[d]  = addr;
      wait_accept(d);
      req_valid[d] = 1'b0;
      run_beats(d, s, pct, stall_beat, stall_len, rand_wr);
   endtask

   initial begin
      int s;
      int r;
      logic [31:0] a;
      logic [31:0] t1 [4];
      t1[0] = 32'h11111111; t1[1] = 32'h22222222; t1[2] = 32'h33333333; t1[3] = 32'h44444444;
      rst = 1'b0; req_valid = '0; resp_ready = '0; init_we = 1'b0;
      init_addr = '0; init_data = '0; req_addr[0] = '0; req_addr[1] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
      for (int i = 0; i < 4; i++) preload(32'h400 + 32'(i * 4), t1[i]);
      for (int i = 0; i < 4; i++) preload(32'h3FF0 + 32'(i * 4), $urandom);

      // Line at 0x400, full throughput: beats 4..7 cycles after acceptance.
      s = beat_log.size();
      request(0, 32'h40C, 100, -1, 0, 1'b0);
      check_eq("t1_count", 32'(beat_log.size() - s), 32'd4);
      if (beat_log.size() >= s + 4) begin
         for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t1_cyc%0d", i), 32'(beat_log[s+i].cyc - acc_cyc[0]), 32'(4 + i));
            check_eq($sformatf("t1_data%0d", i), beat_log[s+i].data, t1[i]);
            check_eq($sformatf("t1_last%0d", i), 32'(beat_log[s+i].last), 32'(i == 3));
         end
      end

      // Backpressure on beat 1 for three cycles.
      s = beat_log.size();
      request(0, 32'h40C, 100, 1, 3, 1'b0);
      check_eq("t2_count", 32'(beat_log.size() - s), 32'd4);
      if (beat_log.size() >= s + 4) begin
         check_eq("t2_hold", 32'(beat_log[s+1].cyc - beat_log[s].cyc), 32'd4);
         check_eq("t2_beat1", beat_log[s+1].data, 32'h22222222);
         check_eq("t2_beat3", beat_log[s+3].data, 32'h44444444);
         check_eq("t2_last", 32'(beat_log[s+3].last), 32'd1);
      end

      // Zero-latency instance: first beat the cycle after acceptance.
      s = beat_log.size();
      request(1, 32'h0, 100, -1, 0, 1'b0);
      if (beat_log.size() >= s + 4) begin
         for (int i = 0; i < 4; i++)
            check_eq($sformatf("t3_cyc%0d", i), 32'(beat_log[s+i].cyc - acc_cyc[1]), 32'(1 + i));
      end

      // Last line in range, then first line past the array.
      s = beat_log.size();
      request(0, 32'h3FF0, 100, -1, 0, 1'b0);
      if (beat_log.size() >= s + 4) check_eq("t4_in_err", 32'(beat_log[s+3].err), 32'd0);
      s = beat_log.size();
      request(0, 32'h4000, 100, -1, 0, 1'b0);
      if (beat_log.size() >= s + 4) begin
         check_eq("t4_out_err", 32'(beat_log[s].err), 32'd1);
         check_eq("t4_out_data", beat_log[s+2].data, 32'd0);
      end

      // Reset during beat 2 abandons the burst; memory survives.
      s = beat_log.size();
      req_valid[0] = 1'b1; req_addr[0] = 32'h400;
      wait_accept(0);
      req_valid[0] = 1'b0;
      resp_ready[0] = 1'b1;
      r = 0;
      while (beat_log.size() < s + 2 && r < 50) begin
         @(posedge clk); #1;
         r++;
      end
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      resp_ready[0] = 1'b0;
      check_eq("t5_abandon", 32'(beat_log.size() - s), 32'd2);
      s = beat_log.size();
      request(0, 32'h400, 100, -1, 0, 1'b0);
      if (beat_log.size() >= s + 4) check_eq("t5_retained", beat_log[s].data, 32'h11111111);

      // Request held through a burst is taken in the idle cycle after it.
      s = beat_log.size();
      req_valid[0] = 1'b1; req_addr[0] = 32'h404;
      wait_accept(0);
      req_addr[0] = 32'h80;
      run_beats(0, s, 100, -1, 0, 1'b0);
      wait_accept(0);
      req_valid[0] = 1'b0;
      if (beat_log.size() >= s + 4)
         check_eq("t6_accept", 32'(acc_cyc[0] - beat_log[s+3].cyc), 32'd1);
      run_beats(0, s + 4, 100, -1, 0, 1'b0);
      if (beat_log.size() >= s + 5)
         check_eq("t6_first", 32'(beat_log[s+4].cyc - acc_cyc[0]), 32'd4);

      // Randomized bursts with backpressure and preload writes into the active line.
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       a = 32'($urandom_range(0, 32'h3FF));
         else if (r == 7) a = 32'h3FF0 + 32'($urandom_range(0, 15));
         else if (r == 8) a = 32'h4000 + 32'($urandom_range(0, 32'hFF));
         else             a = $urandom;
         request($urandom_range(0, 1), a, $urandom_range(30, 100), -1, 0, 1'b1);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
